// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Word-organised memory responder for the LC-3b MP1 memory interface.
//   Accepts one mem_read/mem_write request at a time. It captures the request,
//   waits a programmable number of cycles, performs the access and pulses
//   mem_resp for exactly one cycle.
//
// Parameters
//   LATENCY     edges from acceptance to mem_resp (1..15)
//   DEPTH_LOG2  log2 of number of 16-bit words; index = mem_address[DEPTH_LOG2:1]
//
// Ports
//   clk              rising-edge clock
//   rst_n            synchronous active-low reset
//   mem_read         read request, held until mem_resp
//   mem_write        write request, held until mem_resp (wins over mem_read)
//   mem_byte_enable  write lanes: bit0 -> [7:0], bit1 -> [15:8]
//   mem_address      byte address (bit0 not used for indexing)
//   mem_wdata        write data
//   mem_rdata        read data, updated when a read completes, held otherwise
//   mem_resp         one-cycle completion pulse
//   mem_error        (MEM_ALIGN_CHECK_EN only) misaligned full-word write flag
//
// Optional feature macro: MEM_ALIGN_CHECK_EN
//
// Handshake: the requester raises mem_read or mem_write and holds it (with
// address/data) until it sees mem_resp. Requests are sampled only in IDLE;
// all request fields are captured at acceptance and later changes are ignored.
// -----------------------------------------------------------------------------
module mem_responder #(
  parameter int unsigned LATENCY    = 3,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
`ifdef MEM_ALIGN_CHECK_EN
  output logic        mem_error,
`endif
  output logic        mem_resp
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              count_q, count_d;
  logic                    wr_q, wr_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [15:0]             wdata_q, wdata_d;
  logic [1:0]              be_q, be_d;
  logic                    resp_q, resp_d;
  logic [15:0]             rdata_q, rdata_d;
  logic                    misalign_q, misalign_d;
`ifdef MEM_ALIGN_CHECK_EN
  logic                    err_q, err_d;
`endif

  // Storage: intentionally not reset.
  logic [15:0]             mem_q [DEPTH];
  logic [1:0]              lane_we;

  // Address bits above the index alias; bit0 only matters for the align check.
  logic unused_addr;
  assign unused_addr = ^{mem_address[15:DEPTH_LOG2+1], mem_address[0]};

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    wr_d       = wr_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rdata_d    = rdata_q;
    misalign_d = misalign_q;
    resp_d     = 1'b0;
    lane_we    = 2'b00;
`ifdef MEM_ALIGN_CHECK_EN
    err_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          // A simultaneous read is dropped: the write takes priority.
          wr_d       = mem_write;
          idx_d      = mem_address[DEPTH_LOG2:1];
          wdata_d    = mem_wdata;
          be_d       = mem_byte_enable;
          count_d    = LAT_M1;
`ifdef MEM_ALIGN_CHECK_EN
          misalign_d = mem_write && mem_address[0] && (mem_byte_enable == 2'b11);
`else
          misalign_d = 1'b0;
`endif
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (count_q != 4'd0) begin
          count_d = count_q - 4'd1;
        end else begin
          resp_d  = 1'b1;
          state_d = RESP;
          if (wr_q) begin
            // A misaligned full-word write is reported, never stored.
            lane_we = misalign_q ? 2'b00 : be_q;
`ifdef MEM_ALIGN_CHECK_EN
            err_d   = misalign_q;
`endif
          end else begin
            rdata_d = mem_q[idx_q];
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= 4'd0;
      wr_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= 16'h0000;
      be_q       <= 2'b00;
      resp_q     <= 1'b0;
      rdata_q    <= 16'h0000;
      misalign_q <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wr_q       <= wr_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      resp_q     <= resp_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
`ifdef MEM_ALIGN_CHECK_EN
      err_q      <= err_d;
`endif
    end
  end

  // Storage write port; reset in flight abandons the pending write.
  always_ff @(posedge clk) begin
    if (rst_n && lane_we[0]) mem_q[idx_q][7:0]  <= wdata_q[7:0];
    if (rst_n && lane_we[1]) mem_q[idx_q][15:8] <= wdata_q[15:8];
  end

  assign mem_resp  = resp_q;
  assign mem_rdata = rdata_q;
`ifdef MEM_ALIGN_CHECK_EN
  assign mem_error = err_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//   Directed bench for mem_responder. Each access pushes its hand-computed
//   expected {mem_error, mem_rdata} into exp_q; a monitor pops and compares on
//   every mem_resp pulse. The driver checks response latency and pulse width.
// -----------------------------------------------------------------------------
module tb_mem_responder;

  localparam int unsigned LATENCY    = 3;
  localparam int unsigned DEPTH_LOG2 = 8;
  localparam int          W          = 17;

  logic        clk;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_resp;
`ifdef MEM_ALIGN_CHECK_EN
  logic        mem_error;
`endif

  int errors = 0;
  int checks = 0;
  int resp_count = 0;
  logic [W-1:0] exp_q[$];

  mem_responder #(
    .LATENCY    (LATENCY),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
`ifdef MEM_ALIGN_CHECK_EN
    .mem_error       (mem_error),
`endif
    .mem_resp        (mem_resp)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, act=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: act=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && mem_resp) begin
      logic [W-1:0] e;
      logic         err_act;
      resp_count++;
`ifdef MEM_ALIGN_CHECK_EN
      err_act = mem_error;
`else
      err_act = 1'b0;
`endif
      if (exp_q.size() == 0) begin
        chk("spurious_resp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rdata", {16'h0, mem_rdata}, {16'h0, e[15:0]});
        chk("error", {31'h0, err_act}, {31'h0, e[16]});
      end
    end
  end

  // ---------------- driver ----------------
  task automatic access(input logic rd, input logic wr, input logic [1:0] be,
                        input logic [15:0] addr, input logic [15:0] wd,
                        input logic [15:0] exp_rd, input logic exp_err);
    int lat;
    @(negedge clk);
    mem_read        = rd;
    mem_write       = wr;
    mem_byte_enable = be;
    mem_address     = addr;
    mem_wdata       = wd;
    exp_q.push_back({exp_err, exp_rd});
    @(posedge clk);  // acceptance edge
    #1;
    // Captured values must be used: disturb everything but the request lines.
    mem_address     = 16'($urandom);
    mem_wdata       = 16'($urandom);
    mem_byte_enable = 2'($urandom_range(0, 3));
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (mem_resp) begin
        lat = k;
        break;
      end
    end
    chk("latency", 32'(lat), 32'(LATENCY));
    @(posedge clk);
    #1;
    chk("pulse_width", {31'h0, mem_resp}, 32'd0);
    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rc;
    rst_n = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_byte_enable = 2'b00;
    mem_address = 16'h0000;
    mem_wdata = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_resp", {31'h0, mem_resp}, 32'd0);
    chk("reset_rdata", {16'h0, mem_rdata}, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
    chk("reset_error", {31'h0, mem_error}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Full write then read back.
    access(1'b0, 1'b1, 2'b11, 16'h0010, 16'hBEEF, 16'h0000, 1'b0);
    access(1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);
    // Byte lanes.
    access(1'b0, 1'b1, 2'b01, 16'h0010, 16'h1234, 16'hBEEF, 1'b0);
    access(1'b1, 1'b0, 2'b11, 16'h0010, 16'h0000, 16'hBE34, 1'b0);
    access(1'b0, 1'b1, 2'b10, 16'h0010, 16'hAB00, 16'hBE34, 1'b0);
    access(1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, 16'hAB34, 1'b0);
    access(1'b0, 1'b1, 2'b00, 16'h0010, 16'hFFFF, 16'hAB34, 1'b0);
    access(1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, 16'hAB34, 1'b0);

    // Read held through mem_resp and one cycle beyond: exactly one pulse.
    rc = resp_count;
    access(1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, 16'hAB34, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    chk("single_pulse", 32'(resp_count - rc), 32'd1);
    access(1'b1, 1'b0, 2'b00, 16'h0011, 16'h0000, 16'hAB34, 1'b0);
    chk("two_pulses", 32'(resp_count - rc), 32'd2);

    // Reset in BUSY abandons a pending write.
    access(1'b0, 1'b1, 2'b11, 16'h0020, 16'h5555, 16'hAB34, 1'b0);
    access(1'b1, 1'b0, 2'b00, 16'h0020, 16'h0000, 16'h5555, 1'b0);
    rc = resp_count;
    @(negedge clk);
    mem_write = 1'b1;
    mem_byte_enable = 2'b11;
    mem_address = 16'h0020;
    mem_wdata = 16'hAAAA;
    @(posedge clk);  // accepted
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mem_write = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("no_resp_after_reset", 32'(resp_count - rc), 32'd0);
    chk("rdata_after_reset", {16'h0, mem_rdata}, 32'h0);
    access(1'b1, 1'b0, 2'b00, 16'h0020, 16'h0000, 16'h5555, 1'b0);

    // Write priority over simultaneous read, and index aliasing above bit 8.
    access(1'b1, 1'b1, 2'b11, 16'h0002, 16'h0F0F, 16'h5555, 1'b0);
    access(1'b1, 1'b0, 2'b00, 16'h0202, 16'h0000, 16'h0F0F, 1'b0);

    // Odd address full-word write.
    access(1'b0, 1'b1, 2'b11, 16'h0030, 16'h1111, 16'h0F0F, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
    access(1'b0, 1'b1, 2'b11, 16'h0031, 16'h7777, 16'h0F0F, 1'b1);
    access(1'b1, 1'b0, 2'b00, 16'h0030, 16'h0000, 16'h1111, 1'b0);
    // Reads at odd addresses are never flagged.
    access(1'b1, 1'b0, 2'b11, 16'h0031, 16'h0000, 16'h1111, 1'b0);
`else
    access(1'b0, 1'b1, 2'b11, 16'h0031, 16'h7777, 16'h0F0F, 1'b0);
    access(1'b1, 1'b0, 2'b00, 16'h0030, 16'h0000, 16'h7777, 1'b0);
`endif

    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
